// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer, display and control stages.
// Holds the FSM encoding, the display ceiling and the preset clamp.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MAX_COUNT = 99;

  // Keeps the count inside the two-digit display range.
  function automatic logic [6:0] sat_count(input logic [6:0] v);
    return (v > 7'(MAX_COUNT)) ? 7'(MAX_COUNT) : v;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled, holds otherwise.
// tick marks the wrap cycle so the parent can decrement on the same edge.
module countdown_timer_tick_gen #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown with load/start/stop pulses, feeding a two-digit display.
//
// state | meaning
// IDLE  | preset loaded or after reset, waiting for start
// RUN   | prescaler active, count decrements once per second
// PAUSE | count and prescaler frozen, start resumes
// DONE  | count reached 0, only load or reset leaves
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       start,
  input  logic       stop,
  output logic [6:0] val,
  output logic       running,
  output logic       expired
);

  state_t     state;
  logic [6:0] count;
  logic       tick;
  logic       presc_clr;

  // Fresh runs from IDLE start a full second; resumes from PAUSE do not.
  assign presc_clr = (state == ST_IDLE) && start && !stop && !load;

  countdown_timer_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_RUN),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else if (load) begin
      state   <= ST_IDLE;
      count   <= sat_count(load_val);
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (start && !stop) begin
            if (count != 7'd0) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end else begin
              state   <= ST_DONE;
              expired <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // A tick coinciding with stop still decrements before pausing.
          if (tick && count <= 7'd1) begin
            count   <= '0;
            state   <= ST_DONE;
            running <= 1'b0;
            expired <= 1'b1;
          end else begin
            if (tick) count <= count - 7'd1;
            if (stop) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  assign val = count;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 4-cycle second.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [6:0] load_val = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] val;
  logic       running;
  logic       expired;

  int n_cmp = 0;
  int n_bad = 0;

  countdown_timer #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .val(val), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [6:0] v);
    load = 1'b1; load_val = v; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (val !== 7'd0) begin n_bad++; $display("FAIL reset_val got %0d want 0", val); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
    n_cmp++; if (expired !== 1'b0) begin n_bad++; $display("FAIL reset_expired got %b want 0", expired); end
    step(2);
    rst_n = 1'b1;
    step();
    n_cmp++; if (val !== 7'd0 || running !== 1'b0) begin n_bad++; $display("FAIL reset_release got val=%0d run=%b want 0/0", val, running); end
  endtask

  task automatic test_countdown();
    bit ok;
    do_load(7'd5);
    n_cmp++; if (val !== 7'd5 || running !== 1'b0) begin n_bad++; $display("FAIL cd_load got val=%0d run=%b want 5/0", val, running); end
    do_start();
    n_cmp++; if (running !== 1'b1 || val !== 7'd5) begin n_bad++; $display("FAIL cd_start got val=%0d run=%b want 5/1", val, running); end
    for (int s = 4; s >= 1; s--) begin
      step(3);
      ok = (val === 7'(s + 1));
      step();
      n_cmp++; if (!ok || val !== 7'(s) || running !== 1'b1) begin n_bad++; $display("FAIL cd_step%0d got val=%0d run=%b want %0d/1", s, val, running, s); end
    end
    step(3);
    n_cmp++; if (val !== 7'd1 || expired !== 1'b0 || running !== 1'b1) begin n_bad++; $display("FAIL cd_pre_zero got val=%0d exp=%b run=%b want 1/0/1", val, expired, running); end
    step();
    n_cmp++; if (val !== 7'd0 || expired !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL cd_zero got val=%0d exp=%b run=%b want 0/1/0", val, expired, running); end
    stop = 1'b1; step(); stop = 1'b0;
    do_start();
    step(6);
    n_cmp++; if (val !== 7'd0 || expired !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL done_hold got val=%0d exp=%b run=%b want 0/1/0", val, expired, running); end
  endtask

  task automatic test_clamp_and_zero();
    do_load(7'd120);
    n_cmp++; if (val !== 7'd99 || expired !== 1'b0) begin n_bad++; $display("FAIL clamp got val=%0d exp=%b want 99/0", val, expired); end
    do_load(7'd0);
    n_cmp++; if (val !== 7'd0 || running !== 1'b0) begin n_bad++; $display("FAIL zero_load got val=%0d run=%b want 0/0", val, running); end
    do_start();
    n_cmp++; if (expired !== 1'b1 || running !== 1'b0 || val !== 7'd0) begin n_bad++; $display("FAIL zero_start got exp=%b run=%b val=%0d want 1/0/0", expired, running, val); end
  endtask

  task automatic test_pause_resume();
    bit ok = 1'b1;
    do_load(7'd8);
    do_start();
    step(4);
    n_cmp++; if (val !== 7'd7) begin n_bad++; $display("FAIL pr_at7 got %0d want 7", val); end
    step();
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (running !== 1'b0 || val !== 7'd7) begin n_bad++; $display("FAIL pr_paused got val=%0d run=%b want 7/0", val, running); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (val !== 7'd7 || running !== 1'b0 || expired !== 1'b0) ok = 1'b0;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pr_hold got val=%0d run=%b want 7/0 throughout", val, running); end
    do_start();
    n_cmp++; if (running !== 1'b1 || val !== 7'd7) begin n_bad++; $display("FAIL pr_resume got val=%0d run=%b want 7/1", val, running); end
    step();
    n_cmp++; if (val !== 7'd7) begin n_bad++; $display("FAIL pr_resume_plus1 got %0d want 7", val); end
    step();
    n_cmp++; if (val !== 7'd6) begin n_bad++; $display("FAIL pr_resume_plus2 got %0d want 6", val); end
  endtask

  task automatic test_priority();
    do_load(7'd30);
    do_start();
    step(2);
    load = 1'b1; start = 1'b1; stop = 1'b1; load_val = 7'd110;
    step();
    load = 1'b0; start = 1'b0; stop = 1'b0;
    n_cmp++; if (val !== 7'd99 || running !== 1'b0 || expired !== 1'b0) begin n_bad++; $display("FAIL prio_load got val=%0d run=%b exp=%b want 99/0/0", val, running, expired); end
    step(9);
    n_cmp++; if (val !== 7'd99 || running !== 1'b0) begin n_bad++; $display("FAIL prio_idle_hold got val=%0d run=%b want 99/0", val, running); end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL prio_stop_over_start got run=%b want 0", running); end
  endtask

  task automatic test_stop_on_tick();
    do_load(7'd3);
    do_start();
    step(3);
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++; if (val !== 7'd2 || running !== 1'b0 || expired !== 1'b0) begin n_bad++; $display("FAIL sot got val=%0d run=%b exp=%b want 2/0/0", val, running, expired); end
    step(8);
    n_cmp++; if (val !== 7'd2) begin n_bad++; $display("FAIL sot_hold got %0d want 2", val); end
    do_start();
    step(4);
    n_cmp++; if (val !== 7'd1 || running !== 1'b1) begin n_bad++; $display("FAIL sot_resume got val=%0d run=%b want 1/1", val, running); end
  endtask

  task automatic test_reset_mid_run();
    do_load(7'd50);
    do_start();
    step(40);
    n_cmp++; if (val !== 7'd40 || running !== 1'b1) begin n_bad++; $display("FAIL rmr_at40 got val=%0d run=%b want 40/1", val, running); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (val !== 7'd0 || running !== 1'b0 || expired !== 1'b0) begin n_bad++; $display("FAIL rmr_async got val=%0d run=%b exp=%b want 0/0/0", val, running, expired); end
    step();
    #2 rst_n = 1'b1;
    step(3);
    n_cmp++; if (val !== 7'd0 || running !== 1'b0 || expired !== 1'b0) begin n_bad++; $display("FAIL rmr_idle got val=%0d run=%b exp=%b want 0/0/0", val, running, expired); end
    do_start();
    n_cmp++; if (expired !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL rmr_start got exp=%b run=%b want 1/0", expired, running); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_clamp_and_zero();
    test_pause_resume();
    test_priority();
    test_stop_on_tick();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: CountdownTimer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clk cycles per one-second decrement (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port load, input, 1, single-cycle pulse that presets the count from load_val.
REQ-005 The block SHALL have port load_val, input, 7, preset value in seconds (0..127 accepted).
REQ-006 The block SHALL have port start, input, 1, single-cycle pulse that starts or resumes counting.
REQ-007 The block SHALL have port stop, input, 1, single-cycle pulse that pauses counting.
REQ-008 The block SHALL have port val, output, 7, current count 0..99, direct feed to the two-digit display stage.
REQ-009 The block SHALL have port running, output, 1, high while in RUN.
REQ-010 The block SHALL have port expired, output, 1, high while in DONE.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, PAUSE, DONE.
REQ-012 On load, count SHALL become min(load_val, 99) on the next edge and state SHALL become IDLE, from any state.
REQ-013 In IDLE or PAUSE, start SHALL enter RUN if count > 0; if count == 0, start SHALL enter DONE.
REQ-014 In RUN, stop SHALL enter PAUSE; count and prescaler SHALL hold in PAUSE.
REQ-015 Prescaler SHALL count 0..TICKS_PER_SEC-1 only in RUN, clear on every entry to RUN from IDLE, and resume from its held value on entry from PAUSE.
REQ-016 When the prescaler wraps at TICKS_PER_SEC-1 in RUN, count SHALL decrement by 1 on that edge.
REQ-017 The decrement from 1 to 0 SHALL enter DONE on the same edge; count SHALL never wrap below 0.
REQ-018 In DONE, count SHALL hold at 0; start and stop SHALL be ignored; only load or reset leaves DONE.
REQ-019 Simultaneous pulses SHALL take priority load > stop > start; a tick coinciding with stop SHALL still decrement before the pause.
REQ-020 start in RUN and stop in IDLE, PAUSE or DONE SHALL have no effect.
REQ-021 val, running and expired SHALL be registered or decoded directly from registered state, with no combinational path from inputs.
REQ-022 val SHALL always be in 0..99, so the downstream digit split needs no range check.

Reset
REQ-023 While rst_n is low, count SHALL be 0, the prescaler 0, state IDLE, val 0, running 0 and expired 0, asynchronously.
REQ-024 Reset asserted mid-RUN SHALL abandon the count; after release the block SHALL wait in IDLE for load or start.
REQ-025 Deassertion SHALL take effect at the first clk edge after rst_n rises.

Structure
REQ-026 The FSM state encoding and the constant MAX_COUNT = 99 SHALL live in the shared project package, so they are reused by the display and control stages.
REQ-027 The prescaler SHALL be a sub-module TickGen (inputs clk, rst_n, en, clr; output tick), and the FSM and count SHALL stay in CountdownTimer.

Verification (TICKS_PER_SEC = 4)
REQ-028 The bench SHALL cover: reset, then load 5, then start -> val 5,4,3,2,1,0 at 4-cycle intervals, expired rises with val = 0, running falls on the same edge.
REQ-029 The bench SHALL cover: load_val 120 -> val 99; load_val 0 then start -> DONE next edge, running never high.
REQ-030 The bench SHALL cover: running at val 7 with the prescaler at 2, pulse stop, wait 20 cycles, pulse start -> val stays 7 while paused and reaches 6 exactly 2 cycles after resume.
REQ-031 The bench SHALL cover: load, start and stop asserted in the same cycle during RUN -> load wins, state IDLE, val = min(load_val, 99).
REQ-032 The bench SHALL cover: stop coincident with the prescaler wrap at val 3 -> val 2, state PAUSE.
REQ-033 The bench SHALL cover: rst_n pulsed low mid-RUN between edges at val 40 -> val 0 immediately, state IDLE, and start after release -> DONE.
